// File: rtl/fetch_stage.sv
// F-stage fetch engine: issues in-order instruction fetches under a credit limit,
// buffers responses with their PCs, and redirects by flushing and killing in-flight fetches.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        br_en,
  input  logic [31:0] br_addr,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        d_ready
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [31:0]   r_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_live;
  logic [CW-1:0] r_kill;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [31:0]   r_fifo_data [FIFO_DEPTH];
  logic [31:0]   r_fifo_pc   [FIFO_DEPTH];

  logic [CW+1:0] w_outstanding;
  logic          w_credit_ok;
  logic          w_grant;
  logic          w_rsp;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_br_target;

  // Buffered plus in-flight (live and killed) fetches may never exceed the buffer size.
  assign w_outstanding = {2'b00, r_count} + {2'b00, r_live} + {2'b00, r_kill};
  assign w_credit_ok   = (w_outstanding < (CW+2)'(FIFO_DEPTH));

  assign imem_req    = !reset && !br_en && w_credit_ok;
  assign imem_addr   = r_pc;
  assign instr_valid = !reset && (r_count != '0) && !br_en;
  assign instr_data  = r_fifo_data[r_rd_ptr];
  assign instr_pc    = r_fifo_pc[r_rd_ptr];

  assign w_grant     = imem_req && imem_gnt;
  assign w_rsp       = imem_rvalid && ((r_live != '0) || (r_kill != '0));
  assign w_drop      = imem_rvalid && (r_kill != '0);
  assign w_push      = imem_rvalid && (r_kill == '0) && (r_live != '0) && !br_en;
  assign w_pop       = instr_valid && d_ready;
  assign w_br_target = {br_addr[31:2], 2'b00};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_resp_pc <= RESET_PC;
      r_count   <= '0;
      r_live    <= '0;
      r_kill    <= '0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
    end else if (br_en) begin
      // Everything still in flight becomes a kill; a response landing now is one of them.
      r_pc      <= w_br_target;
      r_resp_pc <= w_br_target;
      r_count   <= '0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_live    <= '0;
      r_kill    <= r_kill + r_live - CW'(w_rsp);
    end else begin
      if (w_grant) r_pc <= r_pc + 32'd4;
      if (w_push) begin
        r_resp_pc <= r_resp_pc + 32'd4;
        r_wr_ptr  <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_live  <= r_live + CW'(w_grant) - CW'(w_push);
      r_kill  <= r_kill - CW'(w_drop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_pc[i]   <= '0;
      end
    end else if (w_push) begin
      r_fifo_data[r_wr_ptr] <= imem_rdata;
      r_fifo_pc[r_wr_ptr]   <= r_resp_pc;
    end
  end

endmodule
